// File: rtl/dsram_like_responder_pkg.sv
// Shared definitions for the data-side SRAM-like responder: size encodings,
// default queue depth, stall-injection LFSR seed and byte-lane/LFSR helpers.
package dsram_like_responder_pkg;

    localparam logic [1:0]  SIZE_BYTE       = 2'd0;
    localparam logic [1:0]  SIZE_HALF       = 2'd1;
    localparam logic [1:0]  SIZE_WORD       = 2'd2;
    localparam int          DSRAM_DEPTH     = 2;
    localparam logic [15:0] DSRAM_LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } resp_entry_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Fibonacci LFSR, taps 16/14/13/11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        logic fb;
        fb = state[15] ^ state[13] ^ state[12] ^ state[10];
        return {state[14:0], fb};
    endfunction

endpackage

// File: rtl/dsram_like_responder_resp_fifo.sv
// Synchronous FIFO holding pending completions; reports count, full and empty.
module dsram_like_responder_resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dsram_like_responder.sv
// Data-side SRAM-like responder: byte-strobed word array with an in-order
// completion queue. Define DSRAM_STALL_INJ_EN to add LFSR-driven stall injection.
module dsram_like_responder
    import dsram_like_responder_pkg::*;
#(
    parameter int    ADDR_W    = 12,
    parameter int    DEPTH     = DSRAM_DEPTH,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_wstrb_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] idx_s;
    logic              accept_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  count_s;
    logic              stall_acc_s;
    logic              stall_pop_s;
    resp_entry_t       push_entry_s;
    resp_entry_t       head_s;
    logic              unused_ok;

`ifdef DSRAM_STALL_INJ_EN
    logic [15:0] lfsr_q;

    // Free-running stall pattern generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= DSRAM_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign stall_acc_s = lfsr_q[0];
    assign stall_pop_s = lfsr_q[1];
`else
    assign stall_acc_s = 1'b0;
    assign stall_pop_s = 1'b0;
`endif

    assign idx_s          = data_addr_i[ADDR_W+1:2];
    assign data_addr_ok_o = !rst && !fifo_full_s && !stall_acc_s;
    assign accept_s       = data_req_i && data_addr_ok_o;
    assign data_data_ok_o = !fifo_empty_s && !stall_pop_s;
    assign pop_s          = data_data_ok_o;
    assign data_rdata_o   = (!fifo_empty_s && !head_s.wr) ? head_s.rdata : 32'h0;

    // Read data is captured at acceptance, before any later write can land.
    always_comb begin
        push_entry_s.wr    = data_wr_i;
        push_entry_s.rdata = 32'h0;
        if (data_wr_i) begin
            push_entry_s.rdata = 32'h0;
        end else begin
            push_entry_s.rdata = mem_q[idx_s];
        end
    end

    // Word array; accepted writes survive a later reset.
    always_ff @(posedge clk) begin
        if (accept_s && data_wr_i) begin
            mem_q[idx_s] <= apply_wstrb(mem_q[idx_s], data_wdata_i, data_wstrb_i);
        end
    end

    dsram_like_responder_resp_fifo #(
        .WIDTH ($bits(resp_entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept_s),
        .pop_i   (pop_s),
        .wdata_i (push_entry_s),
        .rdata_o (head_s),
        .count_o (count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Size is informational and address bits outside the word index are ignored.
    assign unused_ok = &{1'b0, data_size_i == SIZE_BYTE, data_size_i == SIZE_HALF,
                         data_size_i == SIZE_WORD, data_addr_i[31:ADDR_W+2],
                         data_addr_i[1:0], count_s, DSRAM_LFSR_SEED[0]};

endmodule
